riscv_retire_port: RTL and testbench
====================================

Name: riscv_retire_port

Overview:
- Synthesizable retirement monitor inside RISCV_TOP; it produces the NUM_INST, OUTPUT_PORT and HALT observation interface that the sort/instruction benches sample.
- Consumes one retirement record per cycle from the core's writeback stage.
- Counts retired instructions, selects a per-instruction-class result onto OUTPUT_PORT, and detects the halt sequence.
- Once HALT is set, all outputs freeze.

Parameters:
- CNT_W, 32, width of NUM_INST; counter saturates at all-ones.
- MADDR_W, 12, width of the retired data-memory address.
- HALT_INST0, 32'h00c00093, first halt-sequence instruction (addi x1,x0,12).
- HALT_INST1, 32'h00008067, second halt-sequence instruction (jalr x0,0(x1)).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- RET_VALID  in  1  one instruction retires this cycle.
- RET_INST  in  32  retired instruction word.
- RET_RD_WD  in  32  value written to rd by the retired instruction.
- RET_MEM_ADDR  in  MADDR_W  byte address used by a retired store.
- RET_BR_TAKEN  in  1  retired branch was taken.
- NUM_INST  out  CNT_W  retired-instruction count.
- OUTPUT_PORT  out  32  result of the last retired result-producing instruction.
- HALT  out  1  halt sequence retired; sticky.

Behaviour:
- Reset (RST=1 at edge): NUM_INST=0, OUTPUT_PORT=0, HALT=0, state=RUN. Reset wins over every other event, including mid-halt-sequence and while HALTED.
- All outputs are registered. A retirement sampled at edge N is visible after edge N; latency is 1 cycle. RET_* inputs are don't-care when RET_VALID=0.
- Counter:
  - On RET_VALID in state RUN or ARMED, NUM_INST increments by 1.
  - At all-ones it holds; no wrap.
  - Every opcode is counted, including unknown opcodes and both halt-sequence instructions.
- OUTPUT_PORT update on RET_VALID, by opcode RET_INST[6:0]:
  - OP 0110011, OP-IMM 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: RET_RD_WD.
  - STORE 0100011: RET_MEM_ADDR zero-extended to 32 bits.
  - BRANCH 1100011: {31'b0, RET_BR_TAKEN}.
  - Any other opcode: OUTPUT_PORT unchanged.
  - A retired instruction equal to HALT_INST1 in state ARMED leaves OUTPUT_PORT unchanged.
- FSM states RUN, ARMED, HALTED:
  - RUN: RET_VALID with RET_INST==HALT_INST0 -> ARMED; otherwise stay.
  - ARMED:
    - RET_VALID with RET_INST==HALT_INST1 -> HALTED; HALT=1 on the same edge the count includes it.
    - RET_VALID with RET_INST==HALT_INST0 -> stay ARMED.
    - RET_VALID with any other instruction -> RUN.
    - RET_VALID=0 (bubble) -> stay ARMED. Bubbles never break the sequence.
  - HALTED: terminal until RST. RET_VALID is ignored; NUM_INST, OUTPUT_PORT and HALT hold.
- Simultaneous events: RST with RET_VALID -> reset result. A retirement of HALT_INST1 in RUN state is an ordinary JALR: counted and OUTPUT_PORT=RET_RD_WD.

Test Plan:
- Reset, then retire addi with RET_RD_WD=32'h0f00 -> one cycle later NUM_INST=1, OUTPUT_PORT=32'h0f00, HALT=0.
- Retire sw with RET_MEM_ADDR=12'he54, then bge with RET_BR_TAKEN=1 -> OUTPUT_PORT=32'h00000e54, then 32'h00000001; NUM_INST=2. An unknown opcode 7'b0001111 next -> NUM_INST=3, OUTPUT_PORT stays 1.
- Retire 32'h00c00093 (RD_WD=12), two bubble cycles, then 32'h00008067 -> NUM_INST=2, OUTPUT_PORT=32'hc, HALT=1. Further retirements change nothing.
- Retire 32'h00c00093, then an add (RD_WD=5), then 32'h00008067 (RD_WD=7) -> HALT stays 0, NUM_INST=3, OUTPUT_PORT=7.
- With CNT_W=4, retire 17 instructions -> NUM_INST holds 4'hf.
- Assert RST in ARMED state and in HALTED state -> all outputs 0 next cycle. A subsequent lone 32'h00008067 does not halt.

Source files
------------

// File: rtl/riscv_retire_port.sv
// riscv_retire_port: retirement monitor producing NUM_INST, OUTPUT_PORT and sticky HALT
module riscv_retire_port #(
  parameter int CNT_W = 32,
  parameter int MADDR_W = 12,
  parameter logic [31:0] HALT_INST0 = 32'h00c00093,
  parameter logic [31:0] HALT_INST1 = 32'h00008067
) (
  input  logic CLK,
  input  logic RST,
  input  logic RET_VALID,
  input  logic [31:0] RET_INST,
  input  logic [31:0] RET_RD_WD,
  input  logic [MADDR_W-1:0] RET_MEM_ADDR,
  input  logic RET_BR_TAKEN,
  output logic [CNT_W-1:0] NUM_INST,
  output logic [31:0] OUTPUT_PORT,
  output logic HALT
);
  typedef enum logic [1:0] {RUN, ARMED, HALTED} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [31:0] out_nx;
  logic live, rd_op, halt_fin;
  logic [6:0] op;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      NUM_INST <= '0;
      OUTPUT_PORT <= '0;
      HALT <= 1'b0;
    end else begin
      state <= state_nx;
      NUM_INST <= cnt_nx;
      OUTPUT_PORT <= out_nx;
      HALT <= state_nx == HALTED;
    end
  end
  always_comb begin
    state_nx = state;
    if (RET_VALID && state == RUN)
      state_nx = RET_INST == HALT_INST0 ? ARMED : RUN;
    else if (RET_VALID && state == ARMED)
      state_nx = RET_INST == HALT_INST1 ? HALTED : RET_INST == HALT_INST0 ? ARMED : RUN;
  end
  // the closing jalr of the halt pair is counted but never shown on the port
  always_comb begin
    op = RET_INST[6:0];
    live = RET_VALID && state != HALTED;
    halt_fin = state == ARMED && RET_INST == HALT_INST1;
    rd_op = op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 || op == 7'b0110111 ||
            op == 7'b0010111 || op == 7'b1101111 || op == 7'b1100111;
    cnt_nx = live && !(&NUM_INST) ? NUM_INST + CNT_W'(1) : NUM_INST;
    out_nx = !live || halt_fin ? OUTPUT_PORT :
             rd_op ? RET_RD_WD :
             op == 7'b0100011 ? 32'(RET_MEM_ADDR) :
             op == 7'b1100011 ? {31'b0, RET_BR_TAKEN} : OUTPUT_PORT;
  end
endmodule

// File: tb/tb_riscv_retire_port.sv
// tb_riscv_retire_port: directed tests of counting, result selection, halt detection and reset
module tb_riscv_retire_port;
  logic CLK = 0, RST = 0, RET_VALID = 0, RET_BR_TAKEN = 0;
  logic [31:0] RET_INST = 0, RET_RD_WD = 0;
  logic [11:0] RET_MEM_ADDR = 0;
  logic [31:0] num, outp;
  logic halt;
  logic [3:0] num4;
  logic [31:0] out4;
  logic halt4;
  int n_cmp = 0, n_bad = 0;
  localparam logic [31:0] H0 = 32'h00c00093, H1 = 32'h00008067;
  localparam logic [31:0] ADDI = 32'h00100113, SW = 32'h00112023, BGE = 32'h0020d463;
  localparam logic [31:0] FENCE = 32'h0000000f, ADD = 32'h002081b3, LUI = 32'h123450b7;

  always #5 CLK = ~CLK;

  riscv_retire_port dut (.CLK(CLK), .RST(RST), .RET_VALID(RET_VALID), .RET_INST(RET_INST),
    .RET_RD_WD(RET_RD_WD), .RET_MEM_ADDR(RET_MEM_ADDR), .RET_BR_TAKEN(RET_BR_TAKEN),
    .NUM_INST(num), .OUTPUT_PORT(outp), .HALT(halt));
  riscv_retire_port #(.CNT_W(4)) dut4 (.CLK(CLK), .RST(RST), .RET_VALID(RET_VALID), .RET_INST(RET_INST),
    .RET_RD_WD(RET_RD_WD), .RET_MEM_ADDR(RET_MEM_ADDR), .RET_BR_TAKEN(RET_BR_TAKEN),
    .NUM_INST(num4), .OUTPUT_PORT(out4), .HALT(halt4));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic ret(input logic [31:0] inst, input logic [31:0] wd, input logic [11:0] addr, input logic tk);
    RET_VALID = 1; RET_INST = inst; RET_RD_WD = wd; RET_MEM_ADDR = addr; RET_BR_TAKEN = tk;
    step();
    RET_VALID = 0; RET_INST = 32'hdeadbeef; RET_RD_WD = 32'hbad0bad0;
  endtask

  task automatic do_reset();
    RST = 1; step(); RST = 0;
  endtask

  task automatic test_reset();
    RET_VALID = 1; RET_INST = ADDI; RET_RD_WD = 32'h77;
    do_reset();
    RET_VALID = 0;
    n_cmp++;
    if ({num, outp, halt} !== {32'd0, 32'd0, 1'b0}) begin
      n_bad++; $display("FAIL reset: num=%0h out=%0h halt=%0b want 0/0/0", num, outp, halt);
    end
  endtask

  task automatic test_result_select();
    do_reset();
    ret(ADDI, 32'h0f00, 12'h0, 0);
    n_cmp++;
    if ({num, outp, halt} !== {32'd1, 32'h0f00, 1'b0}) begin
      n_bad++; $display("FAIL addi: num=%0h out=%0h halt=%0b want 1/f00/0", num, outp, halt);
    end
    do_reset();
    ret(SW, 32'h1111, 12'he54, 0);
    n_cmp++;
    if ({num, outp} !== {32'd1, 32'h00000e54}) begin
      n_bad++; $display("FAIL store: num=%0h out=%0h want 1/e54", num, outp);
    end
    ret(BGE, 32'h2222, 12'h0, 1);
    n_cmp++;
    if ({num, outp} !== {32'd2, 32'h1}) begin
      n_bad++; $display("FAIL branch_taken: num=%0h out=%0h want 2/1", num, outp);
    end
    ret(FENCE, 32'h3333, 12'h0, 0);
    n_cmp++;
    if ({num, outp} !== {32'd3, 32'h1}) begin
      n_bad++; $display("FAIL unknown_op: num=%0h out=%0h want 3/1", num, outp);
    end
    ret(BGE, 32'h4444, 12'h0, 0);
    n_cmp++;
    if ({num, outp} !== {32'd4, 32'h0}) begin
      n_bad++; $display("FAIL branch_not_taken: num=%0h out=%0h want 4/0", num, outp);
    end
    ret(LUI, 32'h12345000, 12'h0, 0);
    n_cmp++;
    if ({num, outp} !== {32'd5, 32'h12345000}) begin
      n_bad++; $display("FAIL lui: num=%0h out=%0h want 5/12345000", num, outp);
    end
    step();
    n_cmp++;
    if ({num, outp} !== {32'd5, 32'h12345000}) begin
      n_bad++; $display("FAIL bubble_hold: num=%0h out=%0h want 5/12345000", num, outp);
    end
    ret(H1, 32'h99, 12'h0, 0);
    n_cmp++;
    if ({num, outp, halt} !== {32'd6, 32'h99, 1'b0}) begin
      n_bad++; $display("FAIL jalr_in_run: num=%0h out=%0h halt=%0b want 6/99/0", num, outp, halt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    ret(H0, 32'd12, 12'h0, 0);
    step(); step();
    n_cmp++;
    if ({num, outp, halt} !== {32'd1, 32'hc, 1'b0}) begin
      n_bad++; $display("FAIL armed_bubbles: num=%0h out=%0h halt=%0b want 1/c/0", num, outp, halt);
    end
    ret(H1, 32'h99, 12'h0, 0);
    n_cmp++;
    if ({num, outp, halt} !== {32'd2, 32'hc, 1'b1}) begin
      n_bad++; $display("FAIL halt: num=%0h out=%0h halt=%0b want 2/c/1", num, outp, halt);
    end
    ret(ADDI, 32'h55, 12'h0, 0);
    ret(SW, 32'h0, 12'h123, 0);
    n_cmp++;
    if ({num, outp, halt} !== {32'd2, 32'hc, 1'b1}) begin
      n_bad++; $display("FAIL halted_freeze: num=%0h out=%0h halt=%0b want 2/c/1", num, outp, halt);
    end
  endtask

  task automatic test_broken_sequence();
    do_reset();
    ret(H0, 32'd12, 12'h0, 0);
    ret(ADD, 32'd5, 12'h0, 0);
    ret(H1, 32'd7, 12'h0, 0);
    n_cmp++;
    if ({num, outp, halt} !== {32'd3, 32'h7, 1'b0}) begin
      n_bad++; $display("FAIL broken_seq: num=%0h out=%0h halt=%0b want 3/7/0", num, outp, halt);
    end
    do_reset();
    ret(H0, 32'd12, 12'h0, 0);
    ret(H0, 32'd13, 12'h0, 0);
    ret(H1, 32'd7, 12'h0, 0);
    n_cmp++;
    if ({num, outp, halt} !== {32'd3, 32'hd, 1'b1}) begin
      n_bad++; $display("FAIL rearm_halt: num=%0h out=%0h halt=%0b want 3/d/1", num, outp, halt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 15; i++) ret(ADDI, i, 12'h0, 0);
    n_cmp++;
    if (num4 !== 4'hf) begin
      n_bad++; $display("FAIL sat_reach: num4=%0h want f", num4);
    end
    ret(ADDI, 32'h15, 12'h0, 0);
    ret(ADDI, 32'h16, 12'h0, 0);
    n_cmp++;
    if ({num4, out4, num} !== {4'hf, 32'h16, 32'd17}) begin
      n_bad++; $display("FAIL sat_hold: num4=%0h out4=%0h num=%0d want f/16/17", num4, out4, num);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    ret(H0, 32'd12, 12'h0, 0);
    RST = 1; RET_VALID = 1; RET_INST = H1; RET_RD_WD = 32'h5;
    step();
    RST = 0; RET_VALID = 0;
    n_cmp++;
    if ({num, outp, halt} !== {32'd0, 32'd0, 1'b0}) begin
      n_bad++; $display("FAIL reset_armed: num=%0h out=%0h halt=%0b want 0/0/0", num, outp, halt);
    end
    ret(H0, 32'd12, 12'h0, 0);
    ret(H1, 32'd1, 12'h0, 0);
    n_cmp++;
    if (halt !== 1'b1) begin
      n_bad++; $display("FAIL halt_before_reset: halt=%0b want 1", halt);
    end
    do_reset();
    n_cmp++;
    if ({num, outp, halt} !== {32'd0, 32'd0, 1'b0}) begin
      n_bad++; $display("FAIL reset_halted: num=%0h out=%0h halt=%0b want 0/0/0", num, outp, halt);
    end
    ret(H1, 32'd3, 12'h0, 0);
    n_cmp++;
    if ({num, outp, halt} !== {32'd1, 32'h3, 1'b0}) begin
      n_bad++; $display("FAIL lone_jalr: num=%0h out=%0h halt=%0b want 1/3/0", num, outp, halt);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_result_select();
    test_halt();
    test_broken_sequence();
    test_saturate();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
